// File: rtl/cpu_pkg.sv
// Shared encodings for the 5-stage pipeline.
// Write-back select, memory FSM states and the MEM/WB bundle.
package cpu_pkg;

    localparam int XLEN    = 32;
    localparam int RADDR_W = 5;

    typedef enum logic [1:0] {
        M2R_ALU = 2'b00,
        M2R_MEM = 2'b01,
        M2R_PC  = 2'b10,
        M2R_RSV = 2'b11
    } m2r_sel_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_e;

    typedef struct packed {
        logic               we;
        logic [RADDR_W-1:0] addr;
        logic [XLEN-1:0]    data;
    } mem_wb_t;

    // A stage needs the data memory for any store or any load.
    function automatic logic needs_access(
        input logic       mem_we,
        input logic [1:0] sel
    );
        return mem_we | (sel == M2R_MEM);
    endfunction

endpackage

// File: rtl/mem_access_fsm.sv
// Data-memory req/ack sequencer for the MEM stage.
// Owns the access state, the DMem request registers and the stall.
module mem_access_fsm
    import cpu_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            acc_i,
    input  logic            we_i,
    input  logic [XLEN-1:0] addr_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic            ack_i,
    output logic            req_o,
    output logic            we_o,
    output logic [XLEN-1:0] addr_o,
    output logic [XLEN-1:0] wdata_o,
    output logic            stall_o,
    output logic            done_o,
    output logic            idle_o
);

    mem_state_e      state_q, state_d;
    logic            req_q, req_d;
    logic            we_q, we_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;

    // State and request registers; reset abandons any open access.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Next state, request capture and stall generation.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        stall_o = 1'b0;
        done_o  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (acc_i) begin
                    state_d = ST_WAIT;
                    req_d   = 1'b1;
                    we_d    = we_i;
                    addr_d  = addr_i;
                    wdata_d = wdata_i;
                    stall_o = 1'b1;
                end
            end
            ST_WAIT: begin
                if (ack_i) begin
                    state_d = ST_IDLE;
                    req_d   = 1'b0;
                    done_o  = 1'b1;
                end else begin
                    stall_o = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign req_o   = req_q;
    assign we_o    = we_q;
    assign addr_o  = addr_q;
    assign wdata_o = wdata_q;
    assign idle_o  = (state_q == ST_IDLE);

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage with branch resolution and the MEM/WB pipeline register.
// Memory handshaking is delegated to mem_access_fsm.
module mem_wb_stage
    import cpu_pkg::*;
(
    input  logic               CLOCK,
    input  logic               RESET_N,
    input  logic               RegWriteEN_In,
    input  logic               MemWriteEN_In,
    input  logic               Beq_In,
    input  logic               Bne_In,
    input  logic               ZeroFlag_In,
    input  logic [1:0]         Mem2RegSEL_In,
    input  logic [XLEN-1:0]    ALUResult_In,
    input  logic [XLEN-1:0]    WriteData_In,
    input  logic [RADDR_W-1:0] RegWBAddr_In,
    input  logic [XLEN-1:0]    PC_In,
    output logic               DMemReq,
    output logic               DMemWE,
    output logic [XLEN-1:0]    DMemAddr,
    output logic [XLEN-1:0]    DMemWData,
    input  logic [XLEN-1:0]    DMemRData,
    input  logic               DMemAck,
    output logic               StallReq,
    output logic               BranchTaken,
    output logic [XLEN-1:0]    BranchTarget,
    output logic               RegWriteEN_Out,
    output logic [RADDR_W-1:0] RegWBAddr_Out,
    output logic [XLEN-1:0]    WBData_Out
);

    logic    acc;
    logic    done;
    logic    idle;
    mem_wb_t memwb_q, memwb_d;

    assign acc = needs_access(MemWriteEN_In, Mem2RegSEL_In);

    mem_access_fsm u_fsm (
        .clk_i   (CLOCK),
        .rst_ni  (RESET_N),
        .acc_i   (acc),
        .we_i    (MemWriteEN_In),
        .addr_i  (ALUResult_In),
        .wdata_i (WriteData_In),
        .ack_i   (DMemAck),
        .req_o   (DMemReq),
        .we_o    (DMemWE),
        .addr_o  (DMemAddr),
        .wdata_o (DMemWData),
        .stall_o (StallReq),
        .done_o  (done),
        .idle_o  (idle)
    );

    // Branches resolve only when no access is in flight.
    always_comb begin
        BranchTaken  = idle & ((Beq_In & ZeroFlag_In) |
                               (Bne_In & ~ZeroFlag_In));
        BranchTarget = PC_In;
    end

    // Write-back select; a stalled stage inserts a bubble.
    always_comb begin
        memwb_d    = memwb_q;
        memwb_d.we = 1'b0;
        if (!StallReq) begin
            memwb_d.we   = RegWriteEN_In;
            memwb_d.addr = RegWBAddr_In;
            if (done) begin
                memwb_d.data = DMemWE ? ALUResult_In : DMemRData;
            end else begin
                case (Mem2RegSEL_In)
                    M2R_PC:  memwb_d.data = PC_In;
                    default: memwb_d.data = ALUResult_In;
                endcase
            end
        end
    end

    // MEM/WB pipeline register.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            memwb_q <= '0;
        end else begin
            memwb_q <= memwb_d;
        end
    end

    assign RegWriteEN_Out = memwb_q.we;
    assign RegWBAddr_Out  = memwb_q.addr;
    assign WBData_Out     = memwb_q.data;

endmodule
